// File: rtl/mesi_snoop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mesi_types (package)
// Brief  : Bus request / MESI state encodings and the snoop next-state rule.
// Rev    : 1.0
// ============================================================================
package mesi_types;

    typedef enum logic [1:0] {
        No_OP   = 2'b00,
        BusRd   = 2'b01,
        BusRdX  = 2'b10,
        BusUpgr = 2'b11
    } bus_request;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        E = 2'b10,
        M = 2'b11
    } mesi_state;

    typedef struct packed {
        mesi_state next;
        logic      err;
    } snoop_result_t;

    // Only meaningful for a hit; an upgrade seen while we hold the line
    // exclusively means two caches believed they owned it.
    function automatic snoop_result_t snoop_next_state(bus_request cmd, mesi_state st);
        snoop_result_t r;
        r.next = st;
        r.err  = 1'b0;
        case (cmd)
            BusRd:   if (st != I) r.next = S;
            BusRdX:  r.next = I;
            BusUpgr: begin
                r.next = I;
                r.err  = (st == M) || (st == E);
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesi_snoop_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mesi_snoop_ctrl
// Brief  : Per-cache snoop controller: lookup, dirty flush, MESI state update.
// Rev    : 1.0
// ============================================================================
module mesi_snoop_ctrl
    import mesi_types::*;
#(
    parameter int CORE_ID   = 0,
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              bus_cmd,
    input  logic [ADDR_W-1:0]       bus_addr,
    input  logic [1:0]              own_cmd,
    input  logic [1:0]              peer_cmd,
    output logic [IDX_W-1:0]        lk_index,
    input  logic [ADDR_W-IDX_W-1:0] lk_tag,
    input  logic [1:0]              lk_state,
    input  logic [DATA_W-1:0]       lk_data,
    output logic                    st_wr_en,
    output logic [IDX_W-1:0]        st_wr_index,
    output logic [1:0]              st_wr_state,
    output logic                    flush_valid,
    input  logic                    flush_ready,
    output logic [ADDR_W-1:0]       flush_addr,
    output logic [DATA_W-1:0]       flush_data,
    output logic                    snoop_done,
    output logic                    snoop_shared,
    output logic                    proto_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_RESP   = 3'd3,
        ST_WAIT   = 3'd4
    } snoop_fsm_t;

    snoop_fsm_t          r_state;
    bus_request          r_cap_cmd;
    logic [ADDR_W-1:0]   r_cap_addr;
    logic                r_hit;
    logic [1:0]          r_new_state;
    logic [DATA_W-1:0]   r_lk_data;
    logic                r_proto_err;

    logic                w_self;
    logic                w_hit;
    logic                w_dirty_read;
    snoop_result_t       w_res;

    // The low-priority port only wins the bus when the high-priority port is idle.
    assign w_self = (CORE_ID == 0) ? (own_cmd != No_OP)
                                   : ((own_cmd != No_OP) && (peer_cmd == No_OP));

    assign w_hit        = (lk_tag == r_cap_addr[ADDR_W-1:IDX_W]) && (lk_state != I);
    assign w_res        = snoop_next_state(r_cap_cmd, mesi_state'(lk_state));
    assign w_dirty_read = w_hit && (lk_state == M) &&
                          ((r_cap_cmd == BusRd) || (r_cap_cmd == BusRdX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cap_cmd   <= No_OP;
            r_cap_addr  <= '0;
            r_hit       <= 1'b0;
            r_new_state <= 2'b00;
            r_lk_data   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((bus_cmd != No_OP) && !w_self) begin
                        r_cap_cmd  <= bus_request'(bus_cmd);
                        r_cap_addr <= bus_addr;
                        r_state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_hit       <= w_hit;
                    r_new_state <= w_res.next;
                    r_lk_data   <= lk_data;
                    if (w_hit && w_res.err) r_proto_err <= 1'b1;
                    r_state <= w_dirty_read ? ST_FLUSH : ST_RESP;
                end
                ST_FLUSH: begin
                    if (flush_ready) r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Hold off until the bus moves on so a held command is snooped once.
                    if ((bus_cmd == No_OP) || (bus_cmd != r_cap_cmd) || (bus_addr != r_cap_addr))
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign lk_index     = r_cap_addr[IDX_W-1:0];
    assign snoop_done   = (r_state == ST_RESP);
    assign snoop_shared = snoop_done && r_hit && (r_cap_cmd == BusRd);
    assign st_wr_en     = snoop_done && r_hit;
    assign st_wr_index  = st_wr_en ? r_cap_addr[IDX_W-1:0] : '0;
    assign st_wr_state  = st_wr_en ? r_new_state : 2'b00;
    assign flush_valid  = (r_state == ST_FLUSH);
    assign flush_addr   = flush_valid ? r_cap_addr : '0;
    assign flush_data   = flush_valid ? r_lk_data : '0;
    assign proto_err    = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mesi_snoop_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mesi_snoop_ctrl
// Brief  : Directed + random bench; core 1 snoops against a cache-array model,
//          core 0 sees an always-invalid cache and checks priority self-detect.
// Rev    : 1.0
// ============================================================================
module tb_mesi_snoop_ctrl;

    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, RDX = 2'd2, UPG = 2'd3;
    localparam logic [1:0] LI = 2'd0, LS = 2'd1, LE = 2'd2, LM = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] bus_cmd;
    logic [7:0] bus_addr;
    logic [1:0] req0, req1;
    logic       flush_ready1;

    logic [5:0] m_tag  [4];
    logic [1:0] m_st   [4];
    logic [7:0] m_data [4];

    logic [1:0] lk_index1, st_wr_index1, st_wr_state1;
    logic       st_wr_en1, flush_valid1, done1, shared1, err1;
    logic [7:0] flush_addr1, flush_data1;
    logic [1:0] lk_index0, st_wr_index0, st_wr_state0;
    logic       st_wr_en0, flush_valid0, done0, shared0, err0;
    logic [7:0] flush_addr0, flush_data0;

    int total = 0;
    int bad   = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    mesi_snoop_ctrl #(.CORE_ID(1), .NUM_LINES(4), .ADDR_W(8), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .own_cmd(req1), .peer_cmd(req0),
        .lk_index(lk_index1), .lk_tag(m_tag[lk_index1]), .lk_state(m_st[lk_index1]),
        .lk_data(m_data[lk_index1]),
        .st_wr_en(st_wr_en1), .st_wr_index(st_wr_index1), .st_wr_state(st_wr_state1),
        .flush_valid(flush_valid1), .flush_ready(flush_ready1),
        .flush_addr(flush_addr1), .flush_data(flush_data1),
        .snoop_done(done1), .snoop_shared(shared1), .proto_err(err1)
    );

    mesi_snoop_ctrl #(.CORE_ID(0), .NUM_LINES(4), .ADDR_W(8), .DATA_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .own_cmd(req0), .peer_cmd(req1),
        .lk_index(lk_index0), .lk_tag(6'd0), .lk_state(LI), .lk_data(8'd0),
        .st_wr_en(st_wr_en0), .st_wr_index(st_wr_index0), .st_wr_state(st_wr_state0),
        .flush_valid(flush_valid0), .flush_ready(1'b1),
        .flush_addr(flush_addr0), .flush_data(flush_data0),
        .snoop_done(done0), .snoop_shared(shared0), .proto_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus transaction seen by both snoopers. Called and returns at a negedge.
    task automatic txn(input logic [1:0] cmd, input logic [7:0] addr,
                       input logic [1:0] r0, input logic [1:0] r1,
                       input int hold, input int rdy_dly,
                       input bit from_wait, input bit release_bus);
        bit         self0, self1, hit, dirty;
        logic [1:0] idx, nxt;
        self0 = (r0 != NOP);
        self1 = (r1 != NOP) && (r0 == NOP);
        idx   = addr[1:0];
        hit   = !self1 && (m_tag[idx] == addr[7:2]) && (m_st[idx] != LI);
        dirty = hit && (m_st[idx] == LM) && (cmd == RD || cmd == RDX);
        nxt   = (cmd == RD) ? LS : LI;
        if (hit && cmd == UPG && (m_st[idx] == LM || m_st[idx] == LE)) exp_err = 1'b1;

        bus_cmd = cmd; bus_addr = addr; req0 = r0; req1 = r1;
        if (from_wait) begin
            @(negedge clk);
            chk("wait_exit_done", 32'(done1), 0);
        end
        @(negedge clk);
        chk("c1_done", 32'(done1), 0);
        chk("c1_done0", 32'(done0), 0);
        chk("c1_flush", 32'(flush_valid1), 0);
        chk("c1_wr", 32'(st_wr_en1), 0);
        if (!self1) chk("c1_lk_index", 32'(lk_index1), 32'(idx));
        @(negedge clk);
        if (dirty) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                chk("fl_valid", 32'(flush_valid1), 1);
                chk("fl_addr", 32'(flush_addr1), 32'(addr));
                chk("fl_data", 32'(flush_data1), 32'(m_data[idx]));
                chk("fl_done", 32'(done1), 0);
                flush_ready1 = (k == rdy_dly);
                @(negedge clk);
            end
            flush_ready1 = 1'b0;
        end
        chk("resp_done", 32'(done1), 32'(!self1));
        chk("resp_done0", 32'(done0), 32'(!self0 && !dirty));
        chk("resp_shared", 32'(shared1), 32'(hit && cmd == RD));
        chk("resp_wr_en", 32'(st_wr_en1), 32'(hit));
        chk("resp_flush", 32'(flush_valid1), 0);
        chk("resp_err", 32'(err1), 32'(exp_err));
        chk("wr_en0", 32'(st_wr_en0), 0);
        if (hit) begin
            chk("resp_wr_idx", 32'(st_wr_index1), 32'(idx));
            chk("resp_wr_state", 32'(st_wr_state1), 32'(nxt));
            m_st[idx] = nxt;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("held_done", 32'(done1), 0);
            chk("held_done0", 32'(done0), 0);
            chk("held_wr", 32'(st_wr_en1), 0);
        end
        if (release_bus) begin
            bus_cmd = NOP; req0 = NOP; req1 = NOP;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] c, ri;
        logic [5:0] tg;
        for (int i = 0; i < 4; i++) begin
            m_tag[i] = 6'h00; m_st[i] = LI; m_data[i] = 8'h00;
        end
        rst = 1'b1; bus_cmd = NOP; bus_addr = 8'h00; req0 = NOP; req1 = NOP;
        flush_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done1), 0);
        chk("rst_flush", 32'(flush_valid1), 0);
        chk("rst_wr", 32'(st_wr_en1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_lk_index", 32'(lk_index1), 0);
        rst = 1'b0;
        @(negedge clk);

        // BusRd hits E -> S, shared
        m_tag[1] = 6'h09; m_st[1] = LE; m_data[1] = 8'h11;
        txn(RD, 8'h25, RD, NOP, 1, 0, 0, 1);
        // BusRdX hits M -> flush with three stalled cycles, then I
        m_st[1] = LM; m_data[1] = 8'hA5;
        txn(RDX, 8'h25, RDX, NOP, 0, 3, 0, 1);
        // Tag miss
        m_tag[1] = 6'h0A; m_st[1] = LS;
        txn(RD, 8'h25, RD, NOP, 0, 0, 0, 1);
        // Core 1 is the requester: only core 0 snoops
        m_tag[1] = 6'h09; m_st[1] = LS;
        txn(RD, 8'h25, NOP, RD, 2, 0, 0, 1);
        // Both requesting, core 0 granted: core 0 treats it as self
        txn(RD, 8'h25, RD, RD, 2, 0, 0, 1);
        // Held BusRd then BusUpgr to the same address without an idle gap
        m_st[1] = LS;
        txn(RD, 8'h25, RD, NOP, 10, 0, 0, 0);
        txn(UPG, 8'h25, UPG, NOP, 1, 0, 1, 1);
        m_st[1] = LM;
        txn(UPG, 8'h25, UPG, NOP, 1, 0, 0, 1);
        chk("err_sticky", 32'(err1), 1);

        // Reset while flushing
        m_tag[1] = 6'h09; m_st[1] = LM; m_data[1] = 8'h3C;
        bus_cmd = RDX; bus_addr = 8'h25; req0 = RDX; req1 = NOP;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_flush", 32'(flush_valid1), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_flush", 32'(flush_valid1), 0);
        chk("mid_rst_faddr", 32'(flush_addr1), 0);
        chk("mid_rst_fdata", 32'(flush_data1), 0);
        chk("mid_rst_done", 32'(done1), 0);
        chk("mid_rst_err", 32'(err1), 0);
        chk("mid_rst_wr", 32'(st_wr_en1), 0);
        exp_err = 1'b0;
        rst = 1'b0; bus_cmd = NOP; req0 = NOP;
        @(negedge clk);
        txn(RD, 8'h25, RD, NOP, 0, 1, 0, 1);

        // Random traffic against the cache-array model
        for (int n = 0; n < 60; n++) begin
            ri = 2'($urandom_range(0, 3));
            tg = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) begin
                m_tag[ri]  = ($urandom_range(0, 3) == 0) ? tg ^ 6'h01 : tg;
                m_st[ri]   = 2'($urandom_range(0, 3));
                m_data[ri] = 8'($urandom_range(0, 255));
            end
            c = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0)
                txn(c, {tg, ri}, NOP, c, $urandom_range(0, 3), 0, 0, 1);
            else
                txn(c, {tg, ri}, c, NOP, $urandom_range(0, 3), $urandom_range(0, 3), 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
